// File: rtl/compuertas_secuenciador.sv
// Self-sweep sequencer for the 3-input gate unit: walks enabled ops 1..6 over all 8 vectors.
// Optional truth-table compare is built only when COMPUERTAS_CHECK_EN is defined.
module compuertas_secuenciador #(
   parameter int unsigned SETTLE  = 1,
   parameter logic [5:0]  OP_MASK = 6'b111111
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abortar,
   input  logic       sal,
   output logic       ent1,
   output logic       ent2,
   output logic       ent3,
   output logic       act,
   output logic [2:0] sel,
   output logic       busy,
   output logic [2:0] op_actual,
   output logic [7:0] tabla,
   output logic       tabla_valid,
   output logic       done,
   output logic       error,
   output logic [5:0] err_mask
);

   localparam logic [3:0] SettleCnt = 4'(SETTLE);

   typedef enum logic [2:0] {StIdle, StArma, StAplica, StReporta, StFin} state_t;

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [2:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] tmp_q, tmp_d;
   logic [7:0] tabla_q, tabla_d;
   logic       tv_q, tv_d;
   logic [2:0] first_op, next_op;
   logic [7:0] tabla_new;

   // Lowest enabled op strictly above cur; 0 when none remain, so the op counter never wraps.
   function automatic logic [2:0] op_after(input logic [2:0] cur);
      logic [2:0] r;
      r = 3'd0;
      for (int k = 6; k >= 1; k--) begin
         if (OP_MASK[k-1] && (3'(k) > cur)) r = 3'(k);
      end
      return r;
   endfunction

   assign first_op  = op_after(3'd0);
   assign next_op   = op_after(op_q);
   assign tabla_new = {sal, tmp_q};

`ifdef COMPUERTAS_CHECK_EN
   logic       error_q, error_d;
   logic [5:0] err_mask_q, err_mask_d;
   logic       mismatch;

   function automatic logic [7:0] expected(input logic [2:0] op);
      case (op)
         3'd1:    return 8'h80;
         3'd2:    return 8'hFE;
         3'd3:    return 8'h96;
         3'd4:    return 8'h7F;
         3'd5:    return 8'h01;
         3'd6:    return 8'h69;
         default: return 8'h00;
      endcase
   endfunction

   assign mismatch = (tabla_new != expected(op_q));
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      tmp_d   = tmp_q;
      tabla_d = tabla_q;
      tv_d    = 1'b0;
`ifdef COMPUERTAS_CHECK_EN
      error_d    = error_q;
      err_mask_d = err_mask_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start && !abortar) begin
               op_d    = first_op;
               state_d = (first_op == 3'd0) ? StFin : StArma;
`ifdef COMPUERTAS_CHECK_EN
               error_d    = 1'b0;
               err_mask_d = 6'd0;
`endif
            end
         end
         StArma: begin
            vec_d   = 3'd0;
            cnt_d   = 4'd0;
            state_d = StAplica;
         end
         StAplica: begin
            if (cnt_q == SettleCnt) begin
               cnt_d = 4'd0;
               // Table and compare are registered on entry so both are visible during REPORTA.
               if (vec_q == 3'd7) begin
                  tabla_d = tabla_new;
                  tv_d    = 1'b1;
                  state_d = StReporta;
`ifdef COMPUERTAS_CHECK_EN
                  if (mismatch) begin
                     error_d                  = 1'b1;
                     err_mask_d[op_q - 3'd1]  = 1'b1;
                  end
`endif
               end else begin
                  tmp_d[vec_q] = sal;
                  vec_d        = vec_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StReporta: begin
            op_d    = next_op;
            state_d = (next_op == 3'd0) ? StFin : StArma;
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (abortar && (state_q != StIdle)) begin
         state_d = StIdle;
         op_d    = 3'd0;
         tabla_d = tabla_q;
         tv_d    = 1'b0;
`ifdef COMPUERTAS_CHECK_EN
         error_d    = error_q;
         err_mask_d = err_mask_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         op_q    <= 3'd0;
         vec_q   <= 3'd0;
         cnt_q   <= 4'd0;
         tmp_q   <= 7'd0;
         tabla_q <= 8'd0;
         tv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         tmp_q   <= tmp_d;
         tabla_q <= tabla_d;
         tv_q    <= tv_d;
      end
   end

`ifdef COMPUERTAS_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         error_q    <= 1'b0;
         err_mask_q <= 6'd0;
      end else begin
         error_q    <= error_d;
         err_mask_q <= err_mask_d;
      end
   end
   assign error    = error_q;
   assign err_mask = err_mask_q;
`else
   assign error    = 1'b0;
   assign err_mask = 6'd0;
`endif

   assign busy             = (state_q != StIdle);
   assign act              = (state_q == StArma) || (state_q == StAplica) ||
                             (state_q == StReporta);
   assign sel              = act ? op_q : 3'd0;
   assign {ent3, ent2, ent1} = (state_q == StAplica) ? vec_q : 3'd0;
   assign op_actual        = op_q;
   assign tabla            = tabla_q;
   assign tabla_valid      = tv_q;
   assign done             = (state_q == StFin);

endmodule

// File: tb/tb_compuertas_secuenciador.sv
// Directed bench: three sequencers (SETTLE=1, SETTLE=3 with delayed gate, sparse OP_MASK)
// driven by shared start/abortar/rst, each next to its own behavioural gate model.
module tb_compuertas_secuenciador;

   logic clk = 1'b0;
   logic rst, start, abortar, force_xor;
   always #5 clk = ~clk;

   logic [2:0] ent1_w, ent2_w, ent3_w, act_w, busy_w, tv_w, done_w, error_w, sal_w;
   logic [2:0] sel_w [3];
   logic [2:0] op_w [3];
   logic [7:0] tabla_w [3];
   logic [5:0] err_mask_w [3];

   int n_vec = 0;
   int n_err = 0;

   localparam logic [7:0] ExpTab [6] = '{8'h80, 8'hFE, 8'h96, 8'h7F, 8'h01, 8'h69};

   function automatic logic gate(input logic [2:0] op, input logic a, input logic b,
                                 input logic c);
      case (op)
         3'd1:    return a & b & c;
         3'd2:    return a | b | c;
         3'd3:    return a ^ b ^ c;
         3'd4:    return ~(a & b & c);
         3'd5:    return ~(a | b | c);
         3'd6:    return ~(a ^ b ^ c);
         default: return 1'b0;
      endcase
   endfunction

   // Gate models: u0 ideal (XOR can be forced low), u1 two-cycle delay, u2 ideal.
   logic d1, d2;
   assign sal_w[0] = act_w[0] & gate(sel_w[0], ent1_w[0], ent2_w[0], ent3_w[0]) &
                     ~(force_xor & (sel_w[0] == 3'd3));
   always @(posedge clk) begin
      d1 <= act_w[1] & gate(sel_w[1], ent1_w[1], ent2_w[1], ent3_w[1]);
      d2 <= d1;
   end
   assign sal_w[1] = d2;
   assign sal_w[2] = act_w[2] & gate(sel_w[2], ent1_w[2], ent2_w[2], ent3_w[2]);

   compuertas_secuenciador #(.SETTLE(1), .OP_MASK(6'b111111)) u0 (
      .clk(clk), .rst(rst), .start(start), .abortar(abortar), .sal(sal_w[0]),
      .ent1(ent1_w[0]), .ent2(ent2_w[0]), .ent3(ent3_w[0]), .act(act_w[0]), .sel(sel_w[0]),
      .busy(busy_w[0]), .op_actual(op_w[0]), .tabla(tabla_w[0]), .tabla_valid(tv_w[0]),
      .done(done_w[0]), .error(error_w[0]), .err_mask(err_mask_w[0]));

   compuertas_secuenciador #(.SETTLE(3), .OP_MASK(6'b111111)) u1 (
      .clk(clk), .rst(rst), .start(start), .abortar(abortar), .sal(sal_w[1]),
      .ent1(ent1_w[1]), .ent2(ent2_w[1]), .ent3(ent3_w[1]), .act(act_w[1]), .sel(sel_w[1]),
      .busy(busy_w[1]), .op_actual(op_w[1]), .tabla(tabla_w[1]), .tabla_valid(tv_w[1]),
      .done(done_w[1]), .error(error_w[1]), .err_mask(err_mask_w[1]));

   compuertas_secuenciador #(.SETTLE(1), .OP_MASK(6'b101000)) u2 (
      .clk(clk), .rst(rst), .start(start), .abortar(abortar), .sal(sal_w[2]),
      .ent1(ent1_w[2]), .ent2(ent2_w[2]), .ent3(ent3_w[2]), .act(act_w[2]), .sel(sel_w[2]),
      .busy(busy_w[2]), .op_actual(op_w[2]), .tabla(tabla_w[2]), .tabla_valid(tv_w[2]),
      .done(done_w[2]), .error(error_w[2]), .err_mask(err_mask_w[2]));

   // Recorded per sweep; cycle n=1 is the cycle right after the start cycle.
   logic [7:0]  rec_tab [3][6];
   logic [2:0]  rec_op  [3][6];
   int          rec_cyc [3][6];
   int          rec_n   [3];
   int          done_cyc[3];
   int          done_n  [3];
   int          err_cyc;
   logic [27:0] snap    [3];

   function automatic logic [27:0] pack(input int d);
      return {busy_w[d], act_w[d], sel_w[d], ent1_w[d], ent2_w[d], ent3_w[d], op_w[d],
              tv_w[d], done_w[d], tabla_w[d], error_w[d], err_mask_w[d]};
   endfunction

   task automatic run_sweep(input int budget, input int restart_at, input int abort_at,
                            input int rst_at);
      for (int d = 0; d < 3; d++) begin
         rec_n[d] = 0; done_cyc[d] = -1; done_n[d] = 0; snap[d] = '1;
      end
      err_cyc = -1;
      @(negedge clk);
      start = 1'b1;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         start = 1'b0; abortar = 1'b0; rst = 1'b0;
         for (int d = 0; d < 3; d++) begin
            if (tv_w[d]) begin
               if (rec_n[d] < 6) begin
                  rec_tab[d][rec_n[d]] = tabla_w[d];
                  rec_op[d][rec_n[d]]  = op_w[d];
                  rec_cyc[d][rec_n[d]] = n;
               end
               rec_n[d]++;
            end
            if (done_w[d]) begin
               if (done_cyc[d] < 0) done_cyc[d] = n;
               done_n[d]++;
            end
            if (n == abort_at + 1 || n == rst_at + 1) snap[d] = pack(d);
         end
         if (error_w[0] && err_cyc < 0) err_cyc = n;
         if (n == restart_at) start = 1'b1;
         if (n == abort_at) abortar = 1'b1;
         if (n == rst_at) rst = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_vec++;
         if (pack(d) !== 28'd0) begin
            n_err++; $display("FAIL reset_outputs dut%0d got %h want 0", d, pack(d));
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_sweep_ideal();
      run_sweep(220, -1, -1, -1);
      for (int k = 0; k < 6; k++) begin
         n_vec++;
         if (rec_tab[0][k] !== ExpTab[k] || rec_op[0][k] !== 3'(k + 1) ||
             rec_cyc[0][k] != 18 * (k + 1)) begin
            n_err++;
            $display("FAIL ideal_pulse%0d got tab=%h op=%0d cyc=%0d want tab=%h op=%0d cyc=%0d",
                     k, rec_tab[0][k], rec_op[0][k], rec_cyc[0][k], ExpTab[k], k + 1,
                     18 * (k + 1));
         end
         n_vec++;
         if (rec_tab[1][k] !== ExpTab[k]) begin
            n_err++;
            $display("FAIL settle3_tab%0d got %h want %h", k, rec_tab[1][k], ExpTab[k]);
         end
      end
      n_vec++;
      if (rec_n[0] != 6 || done_cyc[0] != 109 || done_n[0] != 1) begin
         n_err++; $display("FAIL ideal_done got pulses=%0d done=%0d/%0d want 6 109/1",
                           rec_n[0], done_cyc[0], done_n[0]);
      end
      n_vec++;
      if (error_w[0] !== 1'b0 || err_mask_w[0] !== 6'd0) begin
         n_err++; $display("FAIL ideal_error got %b/%b want 0/0", error_w[0], err_mask_w[0]);
      end
      n_vec++;
      if (rec_n[1] != 6 || done_cyc[1] != 205) begin
         n_err++; $display("FAIL settle3_done got pulses=%0d done=%0d want 6 205",
                           rec_n[1], done_cyc[1]);
      end
      n_vec++;
      if (rec_n[2] != 2 || rec_tab[2][0] !== 8'h7F || rec_op[2][0] !== 3'd4 ||
          rec_tab[2][1] !== 8'h69 || rec_op[2][1] !== 3'd6 || rec_cyc[2][1] != 36 ||
          done_cyc[2] != 37) begin
         n_err++;
         $display("FAIL mask_skip got n=%0d %h/%0d %h/%0d cyc=%0d done=%0d want 2 7f/4 69/6 36 37",
                  rec_n[2], rec_tab[2][0], rec_op[2][0], rec_tab[2][1], rec_op[2][1],
                  rec_cyc[2][1], done_cyc[2]);
      end
   endtask

   task automatic test_check_fault();
      force_xor = 1'b1;
      run_sweep(220, -1, -1, -1);
      force_xor = 1'b0;
      n_vec++;
      if (rec_tab[0][2] !== 8'h00 || rec_tab[0][3] !== 8'h7F || rec_tab[0][5] !== 8'h69) begin
         n_err++; $display("FAIL fault_tables got %h %h %h want 00 7f 69",
                           rec_tab[0][2], rec_tab[0][3], rec_tab[0][5]);
      end
      n_vec++;
      if (done_cyc[0] != 109) begin
         n_err++; $display("FAIL fault_done got %0d want 109", done_cyc[0]);
      end
`ifdef COMPUERTAS_CHECK_EN
      n_vec++;
      if (err_cyc != 54 || error_w[0] !== 1'b1 || err_mask_w[0] !== 6'b000100) begin
         n_err++; $display("FAIL fault_error got cyc=%0d err=%b mask=%b want 54 1 000100",
                           err_cyc, error_w[0], err_mask_w[0]);
      end
`else
      n_vec++;
      if (err_cyc != -1 || error_w[0] !== 1'b0 || err_mask_w[0] !== 6'd0) begin
         n_err++; $display("FAIL fault_error_off got cyc=%0d err=%b mask=%b want -1 0 0",
                           err_cyc, error_w[0], err_mask_w[0]);
      end
`endif
   endtask

   task automatic test_restart_busy();
      run_sweep(220, 20, -1, -1);
      n_vec++;
      if (rec_n[0] != 6 || done_cyc[0] != 109 || done_n[0] != 1 || done_cyc[1] != 205) begin
         n_err++; $display("FAIL restart_ignored got n=%0d done=%0d/%0d u1=%0d want 6 109/1 205",
                           rec_n[0], done_cyc[0], done_n[0], done_cyc[1]);
      end
      n_vec++;
      if (rec_tab[0][2] !== 8'h96 || error_w[0] !== 1'b0 || err_mask_w[0] !== 6'd0) begin
         n_err++; $display("FAIL restart_clears got tab=%h err=%b mask=%b want 96 0 0",
                           rec_tab[0][2], error_w[0], err_mask_w[0]);
      end
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk);
      start = 1'b1; abortar = 1'b1;
      @(negedge clk);
      start = 1'b0; abortar = 1'b0;
      n_vec++;
      if (busy_w !== 3'b000) begin
         n_err++; $display("FAIL start_abort_idle got busy=%b want 000", busy_w);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (busy_w !== 3'b000 || done_w !== 3'b000) begin
         n_err++; $display("FAIL start_abort_idle_hold got busy=%b done=%b want 000 000",
                           busy_w, done_w);
      end
   endtask

   task automatic test_abort();
      // Op 4 vector 3 occupies cycles 62..63 with SETTLE=1.
      run_sweep(120, -1, 62, -1);
      n_vec++;
      if (snap[0][27:15] !== 13'd0 || snap[0][14:7] !== 8'h96) begin
         n_err++; $display("FAIL abort_outputs got ctl=%h tabla=%h want 0 96",
                           snap[0][27:15], snap[0][14:7]);
      end
      n_vec++;
      if (rec_n[0] != 3 || done_n[0] != 0 || tabla_w[0] !== 8'h96 || busy_w[0] !== 1'b0) begin
         n_err++; $display("FAIL abort_after got pulses=%0d done=%0d tabla=%h busy=%b want 3 0 96 0",
                           rec_n[0], done_n[0], tabla_w[0], busy_w[0]);
      end
   endtask

   task automatic test_rst_mid();
      run_sweep(120, -1, -1, 50);
      for (int d = 0; d < 3; d++) begin
         n_vec++;
         if (snap[d] !== 28'd0) begin
            n_err++; $display("FAIL rst_mid dut%0d got %h want 0", d, snap[d]);
         end
      end
      n_vec++;
      if (rec_n[0] != 2 || rec_n[1] != 1 || done_n[0] != 0) begin
         n_err++; $display("FAIL rst_mid_pulses got %0d %0d done=%0d want 2 1 0",
                           rec_n[0], rec_n[1], done_n[0]);
      end
      run_sweep(220, -1, -1, -1);
      for (int k = 0; k < 6; k++) begin
         n_vec++;
         if (rec_tab[0][k] !== ExpTab[k] || rec_op[0][k] !== 3'(k + 1)) begin
            n_err++; $display("FAIL rst_resweep%0d got %h/%0d want %h/%0d",
                              k, rec_tab[0][k], rec_op[0][k], ExpTab[k], k + 1);
         end
      end
      n_vec++;
      if (done_cyc[0] != 109 || done_cyc[1] != 205 || done_cyc[2] != 37) begin
         n_err++; $display("FAIL rst_resweep_done got %0d %0d %0d want 109 205 37",
                           done_cyc[0], done_cyc[1], done_cyc[2]);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abortar = 1'b0; force_xor = 1'b0;
      test_reset();
      test_sweep_ideal();
      test_check_fault();
      test_restart_busy();
      test_start_abort_idle();
      test_abort();
      test_rst_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
